// File: rtl/sobel_div_pkg.sv
// Shared definitions for the sequential signed divider: default widths,
// result latency and the control state encoding.
package sobel_div_pkg;

   localparam int DEF_DIVIDEND_WIDTH = 20;
   localparam int DEF_DIVISOR_WIDTH  = 11;
   localparam int LATENCY            = DEF_DIVIDEND_WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/sobel_div_seq_20s_11s_if.sv
// Operand and result handshake bundle of the sequential signed divider.
// The producer/consumer side uses master, the divider uses slave.
interface sobel_div_seq_20s_11s_if
   import sobel_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
);
   logic                      in_valid;
   logic                      in_ready;
   logic [DIVIDEND_WIDTH-1:0] dividend;
   logic [DIVISOR_WIDTH-1:0]  divisor;
   logic                      out_valid;
   logic                      out_ready;
   logic [DIVIDEND_WIDTH-1:0] quotient;
   logic [DIVISOR_WIDTH-1:0]  remainder;
   logic                      div_by_zero;
   logic                      overflow;

   modport master (
      output in_valid, dividend, divisor, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );

   modport slave (
      input  in_valid, dividend, divisor, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
   );

endinterface

// File: rtl/sobel_div_step.sv
// One restoring shift-subtract step: shift in the next dividend bit and
// subtract |divisor| when it fits, producing one quotient bit.
module sobel_div_step #(
   parameter int DIVISOR_WIDTH = 11
) (
   input  logic [DIVISOR_WIDTH:0]   i_rem,
   input  logic                     i_bit,
   input  logic [DIVISOR_WIDTH-1:0] i_dmag,
   output logic [DIVISOR_WIDTH:0]   o_rem,
   output logic                     o_qbit
);
   localparam int VW = DIVISOR_WIDTH;

   logic [VW+1:0] w_shift;
   logic [VW:0]   w_diff;

   // The shifted value is below 2*|divisor|, so the difference fits VW+1 bits.
   assign w_shift = {i_rem, i_bit};
   assign o_qbit  = (w_shift >= {2'b00, i_dmag});
   assign w_diff  = w_shift[VW:0] - {1'b0, i_dmag};
   assign o_rem   = o_qbit ? w_diff : w_shift[VW:0];

endmodule

// File: rtl/sobel_div_seq_20s_11s.sv
// Iterative signed divider: magnitudes are divided MSB first, one bit per
// cycle, then signs and the divide-by-zero / overflow cases are applied.
module sobel_div_seq_20s_11s
   import sobel_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DEF_DIVIDEND_WIDTH,
   parameter int DIVISOR_WIDTH  = DEF_DIVISOR_WIDTH
) (
   input  logic                   ap_clk,
   input  logic                   ap_rst,
   sobel_div_seq_20s_11s_if.slave bus
);
   localparam int DW = DIVIDEND_WIDTH;
   localparam int VW = DIVISOR_WIDTH;
   localparam int CW = $clog2(DW);

   state_t          r_state;
   logic [DW-1:0]   r_dvd;
   logic [VW-1:0]   r_dmag;
   logic [VW:0]     r_rem;
   logic [CW-1:0]   r_cnt;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_dbz;
   logic            r_ovf;
   logic            r_in_ready;
   logic            r_out_valid;
   logic [DW-1:0]   r_quotient;
   logic [VW-1:0]   r_remainder;
   logic            r_div_by_zero;
   logic            r_overflow;

   logic [DW-1:0]   w_dvd_mag;
   logic [VW-1:0]   w_dsr_mag;
   logic            w_dbz;
   logic            w_ovf;
   logic [DW-1:0]   w_q_signed;
   logic [VW-1:0]   w_r_signed;
   logic [VW:0]     w_rem_next;
   logic            w_q_bit;

   // Magnitudes are unsigned, so |-2^(DW-1)| is representable.
   assign w_dvd_mag  = bus.dividend[DW-1] ? -bus.dividend : bus.dividend;
   assign w_dsr_mag  = bus.divisor[VW-1] ? -bus.divisor : bus.divisor;
   assign w_dbz      = (bus.divisor == '0);
   assign w_ovf      = (bus.dividend == {1'b1, {(DW-1){1'b0}}}) && (bus.divisor == '1);
   assign w_q_signed = r_neg_q ? -r_dvd : r_dvd;
   assign w_r_signed = r_neg_r ? -r_rem[VW-1:0] : r_rem[VW-1:0];

   sobel_div_step #(.DIVISOR_WIDTH(VW)) u_step (
      .i_rem  (r_rem),
      .i_bit  (r_dvd[DW-1]),
      .i_dmag (r_dmag),
      .o_rem  (w_rem_next),
      .o_qbit (w_q_bit)
   );

   // Control FSM and datapath; r_dvd shifts dividend bits out and quotient bits in.
   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         r_state       <= IDLE;
         r_dvd         <= '0;
         r_dmag        <= '0;
         r_rem         <= '0;
         r_cnt         <= '0;
         r_neg_q       <= 1'b0;
         r_neg_r       <= 1'b0;
         r_dbz         <= 1'b0;
         r_ovf         <= 1'b0;
         r_in_ready    <= 1'b1;
         r_out_valid   <= 1'b0;
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && r_in_ready) begin
                  r_dvd         <= w_dvd_mag;
                  r_dmag        <= w_dsr_mag;
                  r_rem         <= '0;
                  r_cnt         <= CW'(DW - 1);
                  r_neg_q       <= bus.dividend[DW-1] ^ bus.divisor[VW-1];
                  r_neg_r       <= bus.dividend[DW-1];
                  r_dbz         <= w_dbz;
                  r_ovf         <= w_ovf;
                  r_div_by_zero <= 1'b0;
                  r_overflow    <= 1'b0;
                  r_in_ready    <= 1'b0;
                  r_state       <= CALC;
               end
            end
            CALC: begin
               r_rem <= w_rem_next;
               r_dvd <= {r_dvd[DW-2:0], w_q_bit};
               if (r_cnt == '0) begin
                  r_state <= FIX;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            FIX: begin
               if (r_dbz) begin
                  r_quotient  <= '1;
                  r_remainder <= '0;
               end else if (r_ovf) begin
                  r_quotient  <= {1'b1, {(DW-1){1'b0}}};
                  r_remainder <= '0;
               end else begin
                  r_quotient  <= w_q_signed;
                  r_remainder <= w_r_signed;
               end
               r_div_by_zero <= r_dbz;
               r_overflow    <= r_ovf;
               r_out_valid   <= 1'b1;
               r_state       <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b1;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   // in_ready must read low for as long as reset is held.
   assign bus.in_ready    = r_in_ready & ~ap_rst;
   assign bus.out_valid   = r_out_valid;
   assign bus.quotient    = r_quotient;
   assign bus.remainder   = r_remainder;
   assign bus.div_by_zero = r_div_by_zero;
   assign bus.overflow    = r_overflow;

endmodule

// File: tb/tb_sobel_div_seq_20s_11s.sv
// Directed and swept checks of the sequential signed divider against
// hand-computed values and a C-semantics reference.
module tb_sobel_div_seq_20s_11s;
   import sobel_div_pkg::*;

   logic ap_clk;
   logic ap_rst;
   int   n_tests;
   int   n_fail;

   sobel_div_seq_20s_11s_if bus ();

   sobel_div_seq_20s_11s dut (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus)
   );

   initial begin
      ap_clk = 1'b0;
      forever #5 ap_clk = ~ap_clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic start_op(input int a, input int b);
      int guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 100) begin
         @(posedge ap_clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         n_tests++; n_fail++;
         $display("FAIL start_timeout: in_ready=%b required 1", bus.in_ready);
      end
      bus.in_valid = 1'b1;
      bus.dividend = 20'(a);
      bus.divisor  = 11'(b);
      @(posedge ap_clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         @(posedge ap_clk); #1;
         lat++;
      end while (bus.out_valid !== 1'b1 && lat < LATENCY + 40);
      if (bus.out_valid !== 1'b1) begin
         n_tests++; n_fail++;
         $display("FAIL done_timeout: out_valid=%b after %0d cycles, required 1", bus.out_valid, lat);
      end
   endtask

   task automatic finish_op();
      bus.out_ready = 1'b1;
      @(posedge ap_clk); #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge ap_clk);
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_tests++;
      if (bus.quotient !== 20'h00000 || bus.remainder !== 11'h000) begin
         n_fail++; $display("FAIL reset_data: got q=%h r=%h want 0/0", bus.quotient, bus.remainder);
      end
      n_tests++;
      if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
         n_fail++; $display("FAIL reset_flags: got dbz=%b ovf=%b want 0/0", bus.div_by_zero, bus.overflow);
      end
      ap_rst = 1'b0;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_signed_div();
      int a_t[4] = '{1000, -1000, 1000, -1000};
      int b_t[4] = '{7, 7, -7, -7};
      int q_t[4] = '{142, -142, -142, 142};
      int r_t[4] = '{6, -6, 6, -6};
      int lat;
      logic [19:0] eq;
      logic [10:0] er;
      for (int i = 0; i < 4; i++) begin
         start_op(a_t[i], b_t[i]);
         wait_done(lat);
         eq = 20'(q_t[i]);
         er = 11'(r_t[i]);
         n_tests++;
         if (bus.quotient !== eq) begin
            n_fail++; $display("FAIL sign_q %0d/%0d: got %0d want %0d", a_t[i], b_t[i], $signed(bus.quotient), q_t[i]);
         end
         n_tests++;
         if (bus.remainder !== er) begin
            n_fail++; $display("FAIL sign_r %0d/%0d: got %0d want %0d", a_t[i], b_t[i], $signed(bus.remainder), r_t[i]);
         end
         n_tests++;
         if ({bus.div_by_zero, bus.overflow} !== 2'b00) begin
            n_fail++; $display("FAIL sign_flags %0d/%0d: got dbz=%b ovf=%b want 0/0", a_t[i], b_t[i], bus.div_by_zero, bus.overflow);
         end
         n_tests++;
         if (lat != 21) begin n_fail++; $display("FAIL sign_latency: got %0d want 21", lat); end
         finish_op();
      end
   endtask

   task automatic test_overflow();
      int lat;
      start_op(-524288, -1);
      wait_done(lat);
      n_tests++;
      if (bus.quotient !== 20'h80000 || bus.remainder !== 11'h000) begin
         n_fail++; $display("FAIL ovf_data: got q=%h r=%h want 80000/000", bus.quotient, bus.remainder);
      end
      n_tests++;
      if (bus.overflow !== 1'b1 || bus.div_by_zero !== 1'b0) begin
         n_fail++; $display("FAIL ovf_flags: got ovf=%b dbz=%b want 1/0", bus.overflow, bus.div_by_zero);
      end
      n_tests++;
      if (lat != 21) begin n_fail++; $display("FAIL ovf_latency: got %0d want 21", lat); end
      finish_op();
   endtask

   task automatic test_div_by_zero();
      int lat;
      start_op(123, 0);
      wait_done(lat);
      n_tests++;
      if (bus.quotient !== 20'hFFFFF || bus.remainder !== 11'h000) begin
         n_fail++; $display("FAIL dbz_data: got q=%h r=%h want fffff/000", bus.quotient, bus.remainder);
      end
      n_tests++;
      if (bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0) begin
         n_fail++; $display("FAIL dbz_flags: got dbz=%b ovf=%b want 1/0", bus.div_by_zero, bus.overflow);
      end
      n_tests++;
      if (lat != 21) begin n_fail++; $display("FAIL dbz_latency: got %0d want 21", lat); end
      finish_op();
      start_op(1000, 7);
      n_tests++;
      if (bus.div_by_zero !== 1'b0) begin n_fail++; $display("FAIL dbz_clear_on_accept: got %b want 0", bus.div_by_zero); end
      wait_done(lat);
      finish_op();
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(500, 9);
      wait_done(lat);
      for (int i = 0; i < 5; i++) begin
         @(posedge ap_clk); #1;
         n_tests++;
         if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.quotient !== 20'd55 ||
             bus.remainder !== 11'd5 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_cycle%0d: got ov=%b ir=%b q=%0d r=%0d dbz=%b ovf=%b want 1 0 55 5 0 0", i,
                     bus.out_valid, bus.in_ready, $signed(bus.quotient), $signed(bus.remainder), bus.div_by_zero, bus.overflow);
         end
      end
      finish_op();
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         n_fail++; $display("FAIL hold_release: got ov=%b ir=%b want 0 1", bus.out_valid, bus.in_ready);
      end
      n_tests++;
      if (bus.quotient !== 20'd55) begin n_fail++; $display("FAIL hold_keep_q: got %0d want 55", $signed(bus.quotient)); end
   endtask

   task automatic test_input_toggle();
      int lat;
      int ready_seen = 0;
      start_op(20000, 13);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = 1'($urandom);
         bus.dividend = 20'($urandom);
         bus.divisor  = 11'($urandom);
         @(posedge ap_clk); #1;
         if (bus.in_ready !== 1'b0) ready_seen++;
      end
      bus.in_valid = 1'b0;
      n_tests++;
      if (ready_seen != 0) begin n_fail++; $display("FAIL toggle_in_ready: in_ready high %0d times want 0", ready_seen); end
      wait_done(lat);
      n_tests++;
      if (bus.quotient !== 20'd1538 || bus.remainder !== 11'd6) begin
         n_fail++; $display("FAIL toggle_result: got q=%0d r=%0d want 1538 6", $signed(bus.quotient), $signed(bus.remainder));
      end
      n_tests++;
      if (lat + 10 != 21) begin n_fail++; $display("FAIL toggle_latency: got %0d want 21", lat + 10); end
      finish_op();
   endtask

   task automatic test_back_to_back();
      int c = 0;
      int first = -1;
      int second = -1;
      int lat;
      logic acc;
      logic [19:0] q_seen = 20'h00000;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.dividend  = 20'd1000;
      bus.divisor   = 11'd7;
      while (second < 0 && c < 80) begin
         acc = bus.in_valid && bus.in_ready;
         @(posedge ap_clk); #1;
         c++;
         if (acc) begin
            if (first < 0) first = c;
            else second = c;
         end
         if (bus.out_valid === 1'b1) q_seen = bus.quotient;
      end
      bus.in_valid = 1'b0;
      n_tests++;
      if (second - first != 23) begin
         n_fail++; $display("FAIL b2b_spacing: accepts at %0d and %0d spacing %0d want 23", first, second, second - first);
      end
      n_tests++;
      if (q_seen !== 20'd142) begin n_fail++; $display("FAIL b2b_first_q: got %0d want 142", $signed(q_seen)); end
      wait_done(lat);
      n_tests++;
      if (bus.quotient !== 20'd142 || lat != 21) begin
         n_fail++; $display("FAIL b2b_second: got q=%0d lat=%0d want 142 21", $signed(bus.quotient), lat);
      end
      finish_op();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int lat;
      start_op(1000, 7);
      repeat (9) begin @(posedge ap_clk); #1; end
      ap_rst = 1'b1;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
         n_fail++; $display("FAIL midrst_ctrl: got ov=%b ir=%b want 0 0", bus.out_valid, bus.in_ready);
      end
      n_tests++;
      if (bus.quotient !== 20'h00000 || bus.remainder !== 11'h000 || bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0) begin
         n_fail++; $display("FAIL midrst_data: got q=%h r=%h dbz=%b ovf=%b want 0", bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
      end
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         n_fail++; $display("FAIL midrst_release: got ir=%b ov=%b want 1 0", bus.in_ready, bus.out_valid);
      end
      start_op(32767, -3);
      wait_done(lat);
      n_tests++;
      if (bus.quotient !== 20'(-10922) || bus.remainder !== 11'd1) begin
         n_fail++; $display("FAIL midrst_next: got q=%0d r=%0d want -10922 1", $signed(bus.quotient), $signed(bus.remainder));
      end
      n_tests++;
      if (bus.div_by_zero !== 1'b0 || bus.overflow !== 1'b0 || lat != 21) begin
         n_fail++; $display("FAIL midrst_next_flags: got dbz=%b ovf=%b lat=%0d want 0 0 21", bus.div_by_zero, bus.overflow, lat);
      end
      finish_op();
   endtask

   task automatic test_sweep();
      int dvd_c[9] = '{0, 1, -1, -524288, 524287, 1000, -1000, -1024, 1023};
      int dsr_c[8] = '{0, 1, -1, -1024, 1023, 7, -7, 2};
      int a;
      int b;
      int lat;
      logic [19:0] eq;
      logic [10:0] er;
      logic ed;
      logic eo;
      for (int k = 0; k < 72 + 600; k++) begin
         if (k < 72) begin
            a = dvd_c[k / 8];
            b = dsr_c[k % 8];
         end else begin
            a = int'($urandom_range(0, 1048575)) - 524288;
            b = int'($urandom_range(0, 2047)) - 1024;
         end
         ed = 1'b0;
         eo = 1'b0;
         if (b == 0) begin
            eq = 20'hFFFFF; er = 11'h000; ed = 1'b1;
         end else if (a == -524288 && b == -1) begin
            eq = 20'h80000; er = 11'h000; eo = 1'b1;
         end else begin
            eq = 20'(a / b); er = 11'(a % b);
         end
         start_op(a, b);
         wait_done(lat);
         n_tests++;
         if (bus.quotient !== eq || bus.remainder !== er || bus.div_by_zero !== ed || bus.overflow !== eo) begin
            n_fail++;
            $display("FAIL sweep %0d/%0d: got q=%0d r=%0d dbz=%b ovf=%b want q=%0d r=%0d dbz=%b ovf=%b", a, b,
                     $signed(bus.quotient), $signed(bus.remainder), bus.div_by_zero, bus.overflow,
                     $signed(eq), $signed(er), ed, eo);
         end
         finish_op();
      end
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      ap_rst        = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.dividend  = 20'h00000;
      bus.divisor   = 11'h000;
      test_reset();
      test_signed_div();
      test_overflow();
      test_div_by_zero();
      test_backpressure();
      test_input_toggle();
      test_back_to_back();
      test_reset_mid_op();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
